r_rename: RTL and testbench

- Register-rename stage directly downstream of the post-decode queue.
- Consumes one decoded instruction per cycle.
- Maps its architectural source and destination registers onto physical registers, using a speculative RAT and a circular free list.
- Presents the renamed instruction to dispatch through a registered valid/ready output.
- A committed-state copy (architectural RAT plus commit head pointer) allows single-cycle recovery on the global flush.

---
 rtl/r_rename_if.sv | 34 +++
 rtl/r_rename.sv | 91 +++++++++
 tb/tb_r_rename.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/r_rename_if.sv
// Rename-stage bus: decoded-instruction input, renamed output to dispatch, and commit/free port.
interface r_rename_if #(
  parameter int PHY_REGS  = 64,
  parameter int ARCH_REGS = 32,
  parameter int PAYLOAD_W = 64
);
  localparam int PW = $clog2(PHY_REGS);
  localparam int AW = $clog2(ARCH_REGS);

  logic                 in_valid, in_ready;
  logic [AW-1:0]        in_rj, in_rk, in_rd;
  logic                 in_rd_we;
  logic [PAYLOAD_W-1:0] in_payload;

  logic                 out_valid, out_ready;
  logic [PW-1:0]        out_prj, out_prk, out_prd, out_old_prd;
  logic                 out_rd_we;
  logic [PAYLOAD_W-1:0] out_payload;

  logic                 commit_valid, commit_rd_we;
  logic [AW-1:0]        commit_rd;
  logic [PW-1:0]        commit_prd, commit_old_prd;

  modport master (
    output in_valid, in_rj, in_rk, in_rd, in_rd_we, in_payload, out_ready,
           commit_valid, commit_rd_we, commit_rd, commit_prd, commit_old_prd,
    input  in_ready, out_valid, out_prj, out_prk, out_prd, out_old_prd, out_rd_we, out_payload
  );
  modport slave (
    input  in_valid, in_rj, in_rk, in_rd, in_rd_we, in_payload, out_ready,
           commit_valid, commit_rd_we, commit_rd, commit_prd, commit_old_prd,
    output in_ready, out_valid, out_prj, out_prk, out_prd, out_old_prd, out_rd_we, out_payload
  );
endinterface

// File: rtl/r_rename.sv
// Register rename: speculative RAT + circular free list, committed copy for one-cycle flush recovery.
module r_rename #(
  parameter int PHY_REGS  = 64,
  parameter int ARCH_REGS = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       g_flush,
  r_rename_if.slave                  rn,
  output logic [$clog2(PHY_REGS):0]  free_cnt
);
  localparam int PW       = $clog2(PHY_REGS);
  localparam int AW       = $clog2(ARCH_REGS);
  localparam int FL_DEPTH = PHY_REGS - ARCH_REGS;
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW-1:0] spec_rat [ARCH_REGS];
  logic [PW-1:0] arch_rat [ARCH_REGS];
  logic [PW-1:0] fl       [PHY_REGS];
  logic [PW:0]   head, tail, commit_head, commit_head_nxt;
  logic          alloc, accept, do_alloc, commit_free;
  logic [PAYLOAD_W-1:0] payload_q;

  assign free_cnt        = tail - head;
  assign alloc           = rn.in_rd_we && (rn.in_rd != '0);
  assign rn.in_ready     = (!rn.out_valid || rn.out_ready) && !g_flush && !(alloc && free_cnt == '0);
  assign accept          = rn.in_valid && rn.in_ready;
  assign do_alloc        = accept && alloc;
  assign commit_free     = rn.commit_valid && rn.commit_rd_we && (rn.commit_rd != '0);
  assign commit_head_nxt = commit_head + (commit_free ? PTR_ONE : '0);
  assign rn.out_payload  = payload_q;

  // Frees land at tail this edge, so they are only allocatable from the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= PW'(i);
        arch_rat[i] <= PW'(i);
      end
      for (int k = 0; k < PHY_REGS; k++)
        fl[k] <= (k < FL_DEPTH) ? PW'(ARCH_REGS + k) : '0;
      head        <= '0;
      tail        <= (PW+1)'(FL_DEPTH);
      commit_head <= '0;
    end else begin
      if (commit_free) begin
        arch_rat[rn.commit_rd]  <= rn.commit_prd;
        fl[tail[PW-1:0]]        <= rn.commit_old_prd;
        tail                    <= tail + PTR_ONE;
      end
      commit_head <= commit_head_nxt;
      if (g_flush) begin
        // Recover from the committed map, folding in a commit retiring this same cycle.
        for (int i = 0; i < ARCH_REGS; i++)
          spec_rat[i] <= (commit_free && rn.commit_rd == AW'(i)) ? rn.commit_prd : arch_rat[i];
        head <= commit_head_nxt;
      end else if (do_alloc) begin
        spec_rat[rn.in_rd] <= fl[head[PW-1:0]];
        head               <= head + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rn.out_valid   <= 1'b0;
      rn.out_prj     <= '0;
      rn.out_prk     <= '0;
      rn.out_prd     <= '0;
      rn.out_old_prd <= '0;
      rn.out_rd_we   <= 1'b0;
      payload_q      <= '0;
    end else if (g_flush) begin
      rn.out_valid <= 1'b0;
    end else if (accept) begin
      rn.out_valid   <= 1'b1;
      rn.out_prj     <= (rn.in_rj == '0) ? '0 : spec_rat[rn.in_rj];
      rn.out_prk     <= (rn.in_rk == '0) ? '0 : spec_rat[rn.in_rk];
      rn.out_prd     <= alloc ? fl[head[PW-1:0]] : '0;
      rn.out_old_prd <= alloc ? spec_rat[rn.in_rd] : '0;
      rn.out_rd_we   <= alloc;
      payload_q      <= rn.in_payload;
    end else if (rn.out_ready) begin
      rn.out_valid <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (rst) free_cnt <= (PW+1)'(FL_DEPTH));
  assert property (@(posedge clk) disable iff (rst) commit_free |-> (rn.commit_old_prd != '0));
endmodule

// File: tb/tb_r_rename.sv
// Bench for r_rename: reference model of RATs/free list with an output scoreboard and a retire queue.
module tb_r_rename;
  localparam int PHY_REGS = 64, ARCH_REGS = 32, PAYLOAD_W = 64;
  localparam int PW = 6, AW = 5;

  logic clk = 0, rst = 1, g_flush = 0;
  logic [PW:0] free_cnt;

  r_rename_if #(.PHY_REGS(PHY_REGS), .ARCH_REGS(ARCH_REGS), .PAYLOAD_W(PAYLOAD_W)) bus ();
  r_rename #(.PHY_REGS(PHY_REGS), .ARCH_REGS(ARCH_REGS), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst(rst), .g_flush(g_flush), .rn(bus), .free_cnt(free_cnt));

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] prj, prk, prd, old; logic we; logic [63:0] pl; } exp_t;
  typedef struct { logic [AW-1:0] rd; logic [PW-1:0] prd, old; } rob_t;

  exp_t sb[$];
  rob_t rob[$];
  logic [PW-1:0] m_spec [ARCH_REGS];
  logic [PW-1:0] m_arch [ARCH_REGS];
  logic [PW-1:0] m_fl   [PHY_REGS];
  logic [PW:0]   m_head, m_tail, m_chead;
  logic          m_ov;
  bit            inuse [PHY_REGS];
  bit            chk_dup = 0;
  int n_chk = 0, n_pass = 0, dut_xfer = 0, mdl_acc = 0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < ARCH_REGS; i++) begin m_spec[i] = PW'(i); m_arch[i] = PW'(i); end
    for (int k = 0; k < PHY_REGS; k++) begin
      m_fl[k]  = (k < 32) ? PW'(32 + k) : '0;
      inuse[k] = (k < 32);
    end
    m_head = 0; m_tail = 32; m_chead = 0; m_ov = 0;
    sb.delete(); rob.delete();
  endtask

  task automatic drv_in(logic v, int rj, int rk, int rd, logic we);
    bus.in_valid = v; bus.in_rj = AW'(rj); bus.in_rk = AW'(rk); bus.in_rd = AW'(rd);
    bus.in_rd_we = we; bus.in_payload = {$urandom, $urandom};
  endtask

  task automatic drv_cm(logic v, logic we, int rd, int prd, int old);
    bus.commit_valid = v; bus.commit_rd_we = we; bus.commit_rd = AW'(rd);
    bus.commit_prd = PW'(prd); bus.commit_old_prd = PW'(old);
  endtask

  task automatic idle();
    drv_in(0, 0, 0, 0, 0); bus.in_payload = '0; drv_cm(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; @(posedge clk); #1; rst = 0; m_reset();
  endtask

  // One cycle: check at negedge against the model, then advance the model at the edge.
  task automatic step();
    logic alloc, rdy, acc, cfree;
    logic [AW-1:0] rd, crd;
    logic [PW-1:0] cprd, cold;
    logic [PW:0] fc;
    exp_t e;
    @(negedge clk);
    fc    = m_tail - m_head;
    rd    = bus.in_rd;
    alloc = bus.in_rd_we && rd != '0;
    rdy   = (!m_ov || bus.out_ready) && !g_flush && !(alloc && fc == '0);
    acc   = bus.in_valid && rdy;
    crd = bus.commit_rd; cprd = bus.commit_prd; cold = bus.commit_old_prd;
    cfree = bus.commit_valid && bus.commit_rd_we && crd != '0;
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, m_ov);
    chk("free_cnt", free_cnt, fc);
    if (bus.out_valid && bus.out_ready) dut_xfer++;
    if (m_ov && sb.size() > 0) begin
      chk("out_prj", bus.out_prj, sb[0].prj);
      chk("out_prk", bus.out_prk, sb[0].prk);
      chk("out_rd_we", bus.out_rd_we, sb[0].we);
      if (sb[0].we) begin
        chk("out_prd", bus.out_prd, sb[0].prd);
        chk("out_old_prd", bus.out_old_prd, sb[0].old);
      end
      chk("out_payload", bus.out_payload, sb[0].pl);
      if (bus.out_ready) begin
        if (chk_dup && bus.out_rd_we) begin
          chk("dup_alloc", inuse[bus.out_prd], 0);
          inuse[bus.out_prd] = 1;
        end
        void'(sb.pop_front());
        m_ov = 0;
      end
    end
    if (acc) begin
      e.prj = (bus.in_rj == '0) ? '0 : m_spec[bus.in_rj];
      e.prk = (bus.in_rk == '0) ? '0 : m_spec[bus.in_rk];
      e.we  = alloc;
      e.prd = alloc ? m_fl[m_head[PW-1:0]] : '0;
      e.old = alloc ? m_spec[rd] : '0;
      e.pl  = bus.in_payload;
    end
    @(posedge clk);
    if (g_flush) begin
      m_ov = 0; sb.delete();
    end else if (acc) begin
      sb.push_back(e); m_ov = 1; mdl_acc++;
      if (alloc) begin
        m_spec[rd] = e.prd; m_head++;
        rob.push_back('{rd, e.prd, e.old});
      end
    end
    if (cfree) begin
      m_arch[crd] = cprd; m_fl[m_tail[PW-1:0]] = cold; m_tail++; m_chead++;
      if (chk_dup) inuse[cold] = 0;
    end
    if (g_flush) begin
      for (int i = 0; i < ARCH_REGS; i++) m_spec[i] = m_arch[i];
      m_head = m_chead; rob.delete();
    end
    #1;
  endtask

  initial begin
    idle(); bus.out_ready = 0;
    rst = 1; @(posedge clk); @(posedge clk); #1; rst = 0; m_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_prj", bus.out_prj, 0);
    chk("rst_out_prd", bus.out_prd, 0);
    chk("rst_out_old", bus.out_old_prd, 0);
    chk("rst_out_we", bus.out_rd_we, 0);
    chk("rst_free_cnt", free_cnt, 32);
    bus.out_ready = 1;

    // First rename and back-to-back dependent
    drv_in(1, 5, 0, 5, 1); step();
    chk("t1_prj", bus.out_prj, 5);
    chk("t1_prd", bus.out_prd, 32);
    chk("t1_old", bus.out_old_prd, 5);
    chk("t1_fc", free_cnt, 31);
    drv_in(1, 5, 5, 6, 0); step();
    chk("t1_dep_prj", bus.out_prj, 32);

    // Reset mid-operation with a live input and a pending output
    drv_in(1, 1, 2, 3, 1); do_reset();
    chk("mid_rst_ov", bus.out_valid, 0);
    chk("mid_rst_fc", free_cnt, 32);
    chk("mid_rst_prd", bus.out_prd, 0);

    // Exhaust the free list, stall, bypass with non-allocating ops, then free one
    for (int i = 0; i < 32; i++) begin drv_in(1, 0, 0, 1 + (i % 31), 1); step(); end
    chk("t2_fc0", free_cnt, 0);
    drv_in(1, 0, 0, 9, 1); step();
    chk("t2_stall", bus.in_ready, 0);
    drv_in(1, 0, 0, 0, 1); step();
    drv_in(1, 0, 0, 9, 0); step();
    drv_in(1, 0, 0, 9, 1); drv_cm(1, 1, 1, 32, 7); step();
    drv_cm(0, 0, 0, 0, 0);
    chk("t2_fc1", free_cnt, 1);
    step();
    chk("t2_prd7", bus.out_prd, 7);
    idle(); step();

    // Backpressure: hold, then drain one per cycle
    do_reset(); dut_xfer = 0; mdl_acc = 0; bus.out_ready = 0;
    drv_in(1, 1, 2, 10, 1); step();
    drv_in(1, 10, 0, 11, 1);
    repeat (3) step();
    chk("t3_hold_prd", bus.out_prd, 32);
    bus.out_ready = 1; step();
    for (int i = 0; i < 4; i++) begin drv_in(1, 11 + i, 0, 12 + i, 1); step(); end
    idle(); step(); step();
    chk("t3_drained", bus.out_valid, 0);
    chk("t3_xfers", dut_xfer, mdl_acc);

    // Partial commit then flush
    do_reset();
    drv_in(1, 0, 0, 3, 1); step();
    drv_in(1, 0, 0, 4, 1); step();
    idle(); step();
    drv_cm(1, 1, 3, 32, 3); step();
    drv_cm(0, 0, 0, 0, 0); g_flush = 1; step(); g_flush = 0;
    chk("t4_fc", free_cnt, 32);
    drv_in(1, 3, 4, 7, 1); step();
    chk("t4_prd", bus.out_prd, 33);
    chk("t4_prj", bus.out_prj, 32);
    chk("t4_prk", bus.out_prk, 4);
    idle(); step();

    // Flush and commit in the same cycle
    do_reset();
    drv_in(1, 0, 0, 8, 1); step();
    idle(); drv_cm(1, 1, 8, 32, 8); g_flush = 1; step();
    g_flush = 0; drv_cm(0, 0, 0, 0, 0);
    chk("t5_fc", free_cnt, 32);
    drv_in(1, 8, 0, 9, 1); step();
    chk("t5_prj", bus.out_prj, 32);
    for (int i = 0; i < 30; i++) begin drv_in(1, 0, 0, 1 + (i % 31), 1); step(); end
    drv_in(1, 0, 0, 20, 1); step();
    chk("t5_freed", bus.out_prd, 8);
    idle(); step();

    // Random rename/commit traffic across pointer wrap
    do_reset(); chk_dup = 1;
    for (int c = 0; c < 400; c++) begin
      drv_in($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 3) != 0);
      bus.out_ready = $urandom_range(0, 3) != 0;
      if (rob.size() > 0 && $urandom_range(0, 1) == 1) begin
        drv_cm(1, 1, rob[0].rd, rob[0].prd, rob[0].old);
        void'(rob.pop_front());
      end else if ($urandom_range(0, 7) == 0) begin
        drv_cm(1, 0, $urandom_range(1, 31), $urandom_range(0, 63), 0);
      end else begin
        drv_cm(0, 0, 0, 0, 0);
      end
      step();
    end
    idle(); bus.out_ready = 1; step(); step();
    chk_dup = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
